// File: rtl/sram_arbiter_pkg.sv
// Shared constants, request payload and round-robin pick for the two-port SRAM arbiter.
package sram_arbiter_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 20;
  localparam int unsigned DATA_WIDTH      = 16;
  localparam int unsigned BE_WIDTH        = 2;
  localparam int unsigned STATE_WIDTH     = 2;

  localparam logic [STATE_WIDTH-1:0] ARB_IDLE      = 2'd0;
  localparam logic [STATE_WIDTH-1:0] ARB_GRANT     = 2'd1;
  localparam logic [STATE_WIDTH-1:0] ARB_WAIT_DATA = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef struct packed {
    logic [SRAM_ADDR_WIDTH-1:0] address;
    logic [BE_WIDTH-1:0]        byteenable;
    logic                       read;
    logic                       write;
    logic [DATA_WIDTH-1:0]      writedata;
  } sram_req_t;

  // Two-way round robin: on a tie the port not served last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) begin
      return ~last;
    end
    return req1 ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Avalon-MM style bus bundle used for both requester ports and the bridge-facing port.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = sram_arbiter_pkg::SRAM_ADDR_WIDTH
) ();
  import sram_arbiter_pkg::*;

  logic [ADDR_WIDTH-1:0] address;
  logic [BE_WIDTH-1:0]   byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdataready;
  logic                  waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, readdataready, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, readdataready, waitrequest
  );

endinterface

// File: rtl/sram_arbiter.sv
// Shares the single sram_bridge master port between two requesters, one transaction
// at a time, round-robin, holding the grant until a write is accepted or read data returns.
module sram_arbiter
  import sram_arbiter_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  sram_arbiter_if.slave  s0,
  sram_arbiter_if.slave  s1,
  sram_arbiter_if.master m,
  output logic           busy
);

  logic [STATE_WIDTH-1:0] state;
  logic [STATE_WIDTH-1:0] state_nxt;
  logic                   gnt;
  logic                   gnt_nxt;
  logic                   last;
  logic                   last_nxt;
  logic                   req0;
  logic                   req1;
  sram_req_t              req_g;

  assign req0 = s0.read | s0.write;
  assign req1 = s1.read | s1.write;

  // Request payload of the currently granted port.
  always_comb begin
    req_g = '{address: s0.address, byteenable: s0.byteenable, read: s0.read,
              write: s0.write, writedata: s0.writedata};
    if (gnt == PORT1) begin
      req_g = '{address: s1.address, byteenable: s1.byteenable, read: s1.read,
                write: s1.write, writedata: s1.writedata};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_IDLE;
      gnt   <= PORT0;
      last  <= PORT1;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    gnt_nxt            = gnt;
    last_nxt           = last;
    m.address          = req_g.address;
    m.byteenable       = req_g.byteenable;
    m.writedata        = req_g.writedata;
    m.read             = 1'b0;
    m.write            = 1'b0;
    s0.waitrequest     = 1'b1;
    s1.waitrequest     = 1'b1;
    s0.readdataready   = 1'b0;
    s1.readdataready   = 1'b0;
    s0.readdata        = m.readdata;
    s1.readdata        = m.readdata;
    busy               = (state != ARB_IDLE);

    case (state)
      ARB_IDLE: begin
        if (req0 || req1) begin
          gnt_nxt   = rr_pick(req0, req1, last);
          state_nxt = ARB_GRANT;
        end
      end

      ARB_GRANT: begin
        // A simultaneous read+write issues only the write.
        m.write = req_g.write;
        m.read  = req_g.read & ~req_g.write;
        if (gnt == PORT0) begin
          s0.waitrequest = m.waitrequest;
        end else begin
          s1.waitrequest = m.waitrequest;
        end
        if (!req_g.read && !req_g.write) begin
          state_nxt = ARB_IDLE;
        end else if (!m.waitrequest) begin
          if (req_g.write) begin
            last_nxt  = gnt;
            state_nxt = ARB_IDLE;
          end else begin
            state_nxt = ARB_WAIT_DATA;
          end
        end
      end

      ARB_WAIT_DATA: begin
        if (m.readdataready) begin
          if (gnt == PORT0) begin
            s0.readdataready = 1'b1;
          end else begin
            s1.readdataready = 1'b1;
          end
          last_nxt  = gnt;
          state_nxt = ARB_IDLE;
        end
      end

      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic busy;
  always #5 clock = ~clock;

  sram_arbiter_if s0_bus ();
  sram_arbiter_if s1_bus ();
  sram_arbiter_if m_bus ();

  sram_arbiter dut (
    .clock (clock),
    .reset (reset),
    .s0    (s0_bus),
    .s1    (s1_bus),
    .m     (m_bus),
    .busy  (busy)
  );

  // Requester and bridge stimulus
  logic        p_rd [2];
  logic        p_wr [2];
  logic [19:0] p_addr [2];
  logic [1:0]  p_be [2];
  logic [15:0] p_wd [2];
  logic        br_wait, br_rdr;
  logic [15:0] br_rdata;

  assign s0_bus.read       = p_rd[0];
  assign s0_bus.write      = p_wr[0];
  assign s0_bus.address    = p_addr[0];
  assign s0_bus.byteenable = p_be[0];
  assign s0_bus.writedata  = p_wd[0];
  assign s1_bus.read       = p_rd[1];
  assign s1_bus.write      = p_wr[1];
  assign s1_bus.address    = p_addr[1];
  assign s1_bus.byteenable = p_be[1];
  assign s1_bus.writedata  = p_wd[1];
  assign m_bus.waitrequest   = br_wait;
  assign m_bus.readdataready = br_rdr;
  assign m_bus.readdata      = br_rdata;

  logic        act_wait [2];
  logic        act_rdr [2];
  logic [15:0] act_rdata [2];
  assign act_wait[0]  = s0_bus.waitrequest;
  assign act_wait[1]  = s1_bus.waitrequest;
  assign act_rdr[0]   = s0_bus.readdataready;
  assign act_rdr[1]   = s1_bus.readdataready;
  assign act_rdata[0] = s0_bus.readdata;
  assign act_rdata[1] = s1_bus.readdata;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus (-1 none), whether read data is owed, who was served last.
  int owner;
  int last_srv;
  bit pending;
  int refill_mode = 0;  // 0: drop after accept, 1: keep writing, 2: random traffic

  int          wr_log [$];
  int          rd_port [$];
  logic [15:0] rd_val [$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Compare this cycle's outputs with the model, then advance one clock.
  task automatic step();
    int o;
    bit bus, e_wr, e_rd, owed;
    bit acc [2];
    o    = (owner < 0) ? 0 : owner;
    bus  = (owner >= 0) && !pending;
    e_wr = bus && p_wr[o];
    e_rd = bus && p_rd[o] && !p_wr[o];
    chk("busy", 32'(busy), 32'(owner >= 0));
    chk("m_write", 32'(m_bus.write), 32'(e_wr));
    chk("m_read", 32'(m_bus.read), 32'(e_rd));
    for (int i = 0; i < 2; i++) begin
      owed = pending && (o == i) && br_rdr;
      chk($sformatf("s%0d_wait", i), 32'(act_wait[i]), (bus && o == i) ? 32'(br_wait) : 32'd1);
      chk($sformatf("s%0d_rdr", i), 32'(act_rdr[i]), 32'(owed));
      if (owed) chk($sformatf("s%0d_rdata", i), 32'(act_rdata[i]), 32'(br_rdata));
      acc[i] = bus && (o == i) && !br_wait && (p_rd[i] || p_wr[i]);
    end
    if (e_wr || e_rd) begin
      chk("m_address", 32'(m_bus.address), 32'(p_addr[o]));
      chk("m_byteenable", 32'(m_bus.byteenable), 32'(p_be[o]));
      if (e_wr) chk("m_writedata", 32'(m_bus.writedata), 32'(p_wd[o]));
    end
    if (m_bus.write === 1'b1 && !br_wait) begin
      if (act_wait[0] === 1'b0) wr_log.push_back(0);
      else if (act_wait[1] === 1'b0) wr_log.push_back(1);
    end
    for (int i = 0; i < 2; i++) begin
      if (act_rdr[i] === 1'b1) begin
        rd_port.push_back(i);
        rd_val.push_back(act_rdata[i]);
      end
    end
    if (reset) begin
      owner = -1; pending = 0; last_srv = 1;
    end else if (owner < 0) begin
      if ((p_rd[0] || p_wr[0]) && (p_rd[1] || p_wr[1])) owner = 1 - last_srv;
      else if (p_rd[0] || p_wr[0]) owner = 0;
      else if (p_rd[1] || p_wr[1]) owner = 1;
    end else if (!pending) begin
      if (!(p_rd[o] || p_wr[o])) owner = -1;
      else if (!br_wait) begin
        if (p_wr[o]) begin last_srv = o; owner = -1; end
        else pending = 1;
      end
    end else if (br_rdr) begin
      last_srv = o; owner = -1; pending = 0;
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        if (refill_mode == 1) begin
          p_addr[i] = 20'($urandom);
          p_wd[i]   = 16'($urandom);
        end else begin
          p_rd[i] = 1'b0;
          p_wr[i] = 1'b0;
        end
      end
    end
    if (refill_mode == 2) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_rd[i] && !p_wr[i] && $urandom_range(0, 2) == 0) begin
          int k;
          k = $urandom_range(0, 3);
          p_rd[i]   = (k == 0) || (k == 3);
          p_wr[i]   = (k != 0);
          p_addr[i] = 20'($urandom);
          p_be[i]   = 2'($urandom);
          p_wd[i]   = 16'($urandom);
        end
      end
      br_wait  = ($urandom_range(0, 3) == 0);
      br_rdr   = ($urandom_range(0, 2) == 0);
      br_rdata = 16'($urandom);
    end
  endtask

  task automatic cyc();
    #3;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    p_rd = '{1'b0, 1'b0};
    p_wr = '{1'b0, 1'b0};
    br_wait = 1'b0;
    br_rdr  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    owner = -1; pending = 0; last_srv = 1;
    wr_log.delete();
    rd_port.delete();
    rd_val.delete();
  endtask

  typedef struct {
    logic        rd0, wr0, rd1, wr1, mwait;
    logic        e_rd, e_wr, e_w0, e_w1;
    logic [19:0] e_addr;
    logic [15:0] e_wd;
  } vec_t;

  vec_t vt [6];

  initial begin
    p_addr = '{20'h00010, 20'hABCDE};
    p_be   = '{2'b11, 2'b01};
    p_wd   = '{16'hBEEF, 16'hCAFE};
    br_rdata = 16'h0000;

    // rd0 wr0 rd1 wr1 mwait | m_read m_write s0_wait s1_wait address writedata
    vt[0] = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 20'h00010, 16'hBEEF};
    vt[1] = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 20'hABCDE, 16'h0000};
    vt[2] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 20'h00010, 16'hBEEF};
    vt[3] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 20'h00010, 16'h0000};
    vt[4] = '{1, 1, 0, 0, 0, 0, 1, 0, 1, 20'h00010, 16'hBEEF};
    vt[5] = '{0, 0, 0, 1, 1, 0, 1, 1, 1, 20'hABCDE, 16'hCAFE};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      p_rd[0] = vt[v].rd0; p_wr[0] = vt[v].wr0;
      p_rd[1] = vt[v].rd1; p_wr[1] = vt[v].wr1;
      br_wait = vt[v].mwait;
      #3;
      chk($sformatf("vec%0d_idle_busy", v), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_idle_s0_wait", v), 32'(act_wait[0]), 32'd1);
      chk($sformatf("vec%0d_idle_s1_wait", v), 32'(act_wait[1]), 32'd1);
      step();
      #3;
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'd1);
      chk($sformatf("vec%0d_m_read", v), 32'(m_bus.read), 32'(vt[v].e_rd));
      chk($sformatf("vec%0d_m_write", v), 32'(m_bus.write), 32'(vt[v].e_wr));
      chk($sformatf("vec%0d_s0_wait", v), 32'(act_wait[0]), 32'(vt[v].e_w0));
      chk($sformatf("vec%0d_s1_wait", v), 32'(act_wait[1]), 32'(vt[v].e_w1));
      chk($sformatf("vec%0d_m_address", v), 32'(m_bus.address), 32'(vt[v].e_addr));
      if (vt[v].e_wr) chk($sformatf("vec%0d_m_writedata", v), 32'(m_bus.writedata), 32'(vt[v].e_wd));
    end

    // Granted port drops its request: nothing issued, tie history untouched.
    do_reset();
    p_wr[0] = 1'b1;
    cyc();
    p_wr[0] = 1'b0;
    #3;
    chk("viol_m_write", 32'(m_bus.write), 32'd0);
    chk("viol_busy", 32'(busy), 32'd1);
    step();
    #3;
    chk("viol_back_idle", 32'(busy), 32'd0);
    step();
    p_wr = '{1'b1, 1'b1};
    cyc();
    #3;
    chk("viol_tie_s0_wait", 32'(act_wait[0]), 32'd0);
    step();

    // Simultaneous reads: port 0 first, strobes steered to the owning port.
    do_reset();
    p_rd = '{1'b1, 1'b1};
    cyc();
    cyc();
    br_rdr = 1'b1; br_rdata = 16'h1234;
    cyc();
    br_rdr = 1'b0;
    cyc();
    cyc();
    br_rdr = 1'b1; br_rdata = 16'h5678;
    cyc();
    br_rdr = 1'b0;
    cyc();
    chk("rd_count", 32'(rd_port.size()), 32'd2);
    if (rd_port.size() >= 2) begin
      chk("rd_first_port", 32'(rd_port[0]), 32'd0);
      chk("rd_first_data", 32'(rd_val[0]), 32'h1234);
      chk("rd_second_port", 32'(rd_port[1]), 32'd1);
      chk("rd_second_data", 32'(rd_val[1]), 32'h5678);
    end

    // Bridge stalls a port 1 write for 3 cycles.
    do_reset();
    p_wr[1] = 1'b1;
    br_wait = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("hold_s1_wait", 32'(act_wait[1]), 32'd1);
      chk("hold_m_write", 32'(m_bus.write), 32'd1);
      step();
    end
    br_wait = 1'b0;
    #3;
    chk("hold_accept_s1_wait", 32'(act_wait[1]), 32'd0);
    chk("hold_accept_m_write", 32'(m_bus.write), 32'd1);
    step();
    #3;
    chk("hold_after_busy", 32'(busy), 32'd0);
    step();

    // Slow read data on port 1 blocks a port 0 write until data returns plus one idle cycle.
    do_reset();
    p_rd[1] = 1'b1;
    cyc();
    cyc();
    p_wr[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk("dly_m_write", 32'(m_bus.write), 32'd0);
      chk("dly_s0_wait", 32'(act_wait[0]), 32'd1);
      step();
    end
    br_rdr = 1'b1; br_rdata = 16'h0F0F;
    #3;
    chk("dly_s1_rdr", 32'(act_rdr[1]), 32'd1);
    chk("dly_s0_rdr", 32'(act_rdr[0]), 32'd0);
    step();
    br_rdr = 1'b0;
    #3;
    chk("dly_idle_m_write", 32'(m_bus.write), 32'd0);
    chk("dly_idle_busy", 32'(busy), 32'd0);
    step();
    #3;
    chk("dly_issue_m_write", 32'(m_bus.write), 32'd1);
    chk("dly_issue_s0_wait", 32'(act_wait[0]), 32'd0);
    step();

    // Reset while waiting for read data; the late strobe must be dropped.
    do_reset();
    p_rd[0] = 1'b1;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    br_rdr = 1'b1; br_rdata = 16'h9999;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s0_wait", 32'(act_wait[0]), 32'd1);
    chk("rst_s1_wait", 32'(act_wait[1]), 32'd1);
    chk("rst_s0_rdr", 32'(act_rdr[0]), 32'd0);
    step();
    br_rdr = 1'b0;

    // Both ports saturating with writes alternate strictly.
    do_reset();
    refill_mode = 1;
    p_wr = '{1'b1, 1'b1};
    for (int c = 0; c < 60 && wr_log.size() < 10; c++) cyc();
    refill_mode = 0;
    chk("sat_count", 32'(wr_log.size()), 32'd10);
    for (int i = 0; i < wr_log.size(); i++) begin
      chk($sformatf("sat_order_%0d", i), 32'(wr_log[i]), 32'(i % 2));
    end

    // Random traffic against the reference model.
    do_reset();
    refill_mode = 2;
    repeat (3000) cyc();
    refill_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
